display_scan: RTL and testbench

Time-multiplexed driver for the board's 4-digit common-anode seven-segment display. Takes four BCD digits plus per-digit blank, blink and decimal-point masks. Rotates one active-low anode at a time, driving the matching active-low segment pattern, with an inter-digit blanking gap against ghosting and a frame-coherent input latch. Sits between the stopwatch/counter datapath and the top-level `an`/`sevenseg` pins.

---
 rtl/display_pkg.sv | 24 ++
 rtl/display_scan_chk.sv | 18 +
 rtl/seg_decode.sv | 27 ++
 rtl/display_scan.sv | 133 +++++++++++++
 tb/tb_display_scan.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Segment patterns are active-low, bit order {dp,g,f,e,d,c,b,a}.
package display_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [7:0] seg_t;
    typedef logic [3:0] bcd_t;

    localparam seg_t SEG_OFF = 8'hFF;

    // Digit patterns with dp off; the decoder uses the low seven bits.
    localparam seg_t SEG_0 = 8'hC0;
    localparam seg_t SEG_1 = 8'hF9;
    localparam seg_t SEG_2 = 8'hA4;
    localparam seg_t SEG_3 = 8'hB0;
    localparam seg_t SEG_4 = 8'h99;
    localparam seg_t SEG_5 = 8'h92;
    localparam seg_t SEG_6 = 8'h82;
    localparam seg_t SEG_7 = 8'hF8;
    localparam seg_t SEG_8 = 8'h80;
    localparam seg_t SEG_9 = 8'h90;

endpackage

// File: rtl/display_scan_chk.sv
// Elaboration-time checks on the scan timing parameters.
module display_scan_chk #(
    parameter int SLOT_CYCLES  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int BLINK_FRAMES = 125
) ();

    if (SLOT_CYCLES < 2) begin : g_slot_err
        $error("display_scan: SLOT_CYCLES must be at least 2");
    end
    if (BLANK_CYCLES < 0 || BLANK_CYCLES >= SLOT_CYCLES) begin : g_blank_err
        $error("display_scan: BLANK_CYCLES must be in 0..SLOT_CYCLES-1");
    end
    if (BLINK_FRAMES < 1) begin : g_blink_err
        $error("display_scan: BLINK_FRAMES must be at least 1");
    end

endmodule

// File: rtl/seg_decode.sv
// BCD to active-low {g..a} segment pattern; codes 10-15 leave all segments off.
module seg_decode
    import display_pkg::*;
(
    input  bcd_t       bcd,
    output logic [6:0] seg
);

    // Table lookup of the seven segment lines.
    always_comb begin
        seg = SEG_OFF[6:0];
        case (bcd)
            4'd0:    seg = SEG_0[6:0];
            4'd1:    seg = SEG_1[6:0];
            4'd2:    seg = SEG_2[6:0];
            4'd3:    seg = SEG_3[6:0];
            4'd4:    seg = SEG_4[6:0];
            4'd5:    seg = SEG_5[6:0];
            4'd6:    seg = SEG_6[6:0];
            4'd7:    seg = SEG_7[6:0];
            4'd8:    seg = SEG_8[6:0];
            4'd9:    seg = SEG_9[6:0];
            default: seg = SEG_OFF[6:0];
        endcase
    end

endmodule

// File: rtl/display_scan.sv
// Four-digit common-anode scan driver with inter-digit blanking,
// per-digit blank/blink/dp masks and a frame-coherent input latch.
module display_scan
    import display_pkg::*;
#(
    parameter int SLOT_CYCLES  = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           digits,
    input  logic [NUM_DIGITS-1:0] blank_mask,
    input  logic [NUM_DIGITS-1:0] blink_mask,
    input  logic [NUM_DIGITS-1:0] dp_mask,
    output logic [NUM_DIGITS-1:0] an,
    output seg_t                  sevenseg
);

    localparam int SCW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [SCW-1:0] SC_LAST  = SCW'(SLOT_CYCLES - 1);
    localparam logic [SCW-1:0] SC_BLANK = SCW'(BLANK_CYCLES);
    localparam logic [FCW-1:0] FC_LAST  = FCW'(BLINK_FRAMES - 1);

    display_scan_chk #(
        .SLOT_CYCLES (SLOT_CYCLES),
        .BLANK_CYCLES(BLANK_CYCLES),
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_chk ();

    logic [SCW-1:0]        sc_r;
    logic [1:0]            idx_r;
    logic [FCW-1:0]        fc_r;
    logic                  ph_r;
    logic [15:0]           digits_r;
    logic [NUM_DIGITS-1:0] blank_r, blink_r, dp_r;
    logic [NUM_DIGITS-1:0] an_r;
    seg_t                  seg_r;

    logic                  frame_start_s;
    logic [15:0]           cur_digits_s;
    logic [NUM_DIGITS-1:0] cur_blank_s, cur_blink_s, cur_dp_s;
    bcd_t                  digit_s;
    logic [6:0]            seg7_s;
    logic                  lit_s;
    logic [NUM_DIGITS-1:0] an_next_s;
    seg_t                  seg_next_s;

    assign frame_start_s = (sc_r == '0) && (idx_r == 2'd0);

    // The cycle that loads the latch also drives the output, so it sees the incoming values.
    always_comb begin
        cur_digits_s = digits_r;
        cur_blank_s  = blank_r;
        cur_blink_s  = blink_r;
        cur_dp_s     = dp_r;
        if (frame_start_s) begin
            cur_digits_s = digits;
            cur_blank_s  = blank_mask;
            cur_blink_s  = blink_mask;
            cur_dp_s     = dp_mask;
        end else begin
            cur_digits_s = digits_r;
            cur_blank_s  = blank_r;
            cur_blink_s  = blink_r;
            cur_dp_s     = dp_r;
        end
        digit_s = cur_digits_s[{idx_r, 2'b00} +: 4];
    end

    seg_decode u_dec (
        .bcd(digit_s),
        .seg(seg7_s)
    );

    // Next pin values for the current slot position.
    always_comb begin
        an_next_s  = 4'b1111;
        seg_next_s = SEG_OFF;
        lit_s = (sc_r >= SC_BLANK) && !cur_blank_s[idx_r] && !(cur_blink_s[idx_r] && ph_r);
        if (lit_s) begin
            an_next_s  = ~(4'b0001 << idx_r);
            seg_next_s = {~cur_dp_s[idx_r], seg7_s};
        end else begin
            an_next_s  = 4'b1111;
            seg_next_s = SEG_OFF;
        end
    end

    // Slot/digit/frame counters, blink phase, frame latch and registered pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            sc_r     <= '0;
            idx_r    <= 2'd0;
            fc_r     <= '0;
            ph_r     <= 1'b0;
            digits_r <= 16'h0000;
            blank_r  <= 4'b0000;
            blink_r  <= 4'b0000;
            dp_r     <= 4'b0000;
            an_r     <= 4'b1111;
            seg_r    <= SEG_OFF;
        end else begin
            if (sc_r == SC_LAST) begin
                sc_r  <= '0;
                idx_r <= idx_r + 2'd1;
                if (idx_r == 2'd3) begin
                    if (fc_r == FC_LAST) begin
                        fc_r <= '0;
                        ph_r <= ~ph_r;
                    end else begin
                        fc_r <= fc_r + {{(FCW-1){1'b0}}, 1'b1};
                    end
                end
            end else begin
                sc_r <= sc_r + {{(SCW-1){1'b0}}, 1'b1};
            end
            if (frame_start_s) begin
                digits_r <= digits;
                blank_r  <= blank_mask;
                blink_r  <= blink_mask;
                dp_r     <= dp_mask;
            end
            an_r  <= an_next_s;
            seg_r <= seg_next_s;
        end
    end

    assign an       = an_r;
    assign sevenseg = seg_r;

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan with SLOT_CYCLES=8, BLANK_CYCLES=2, BLINK_FRAMES=2.
module tb_display_scan;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digits = 16'h0000;
    logic [3:0]  blank_mask = 4'b0000;
    logic [3:0]  blink_mask = 4'b0000;
    logic [3:0]  dp_mask = 4'b0000;
    logic [3:0]  an;
    logic [7:0]  sevenseg;

    int tests = 0;
    int fails = 0;
    logic armed = 1'b0;

    display_scan #(
        .SLOT_CYCLES (8),
        .BLANK_CYCLES(2),
        .BLINK_FRAMES(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .digits    (digits),
        .blank_mask(blank_mask),
        .blink_mask(blink_mask),
        .dp_mask   (dp_mask),
        .an        (an),
        .sevenseg  (sevenseg)
    );

    always #5 clk = ~clk;

    // At most one anode may be low at any time once reset has been applied.
    always @(negedge clk) begin
        if (armed) begin
            tests++;
            assert (!$isunknown(an) && $countones(an) >= 3) else begin
                fails++;
                $error("FAIL one_hot_an: an=%b required at most one zero", an);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] ea, input logic [7:0] es);
        tests++;
        assert ({an, sevenseg} === {ea, es}) else begin
            fails++;
            $error("FAIL %s: an=%b seg=%h required an=%b seg=%h", tag, an, sevenseg, ea, es);
        end
    endtask

    // One slot: two blank output cycles, then six cycles of the expected digit.
    task automatic check_slot(input string tag, input logic [3:0] ea, input logic [7:0] es);
        for (int i = 0; i < 8; i++) begin
            step();
            if (i < 2) chk({tag, "_gap"}, 4'b1111, 8'hFF);
            else       chk(tag, ea, es);
        end
    endtask

    task automatic check_frame(input string tag, input logic [3:0] dark,
                               input logic [7:0] s0, input logic [7:0] s1,
                               input logic [7:0] s2, input logic [7:0] s3);
        logic [7:0] s [4];
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        for (int d = 0; d < 4; d++) begin
            if (dark[d]) check_slot($sformatf("%s_d%0d", tag, d), 4'b1111, 8'hFF);
            else         check_slot($sformatf("%s_d%0d", tag, d), ~(4'b0001 << d), s[d]);
        end
    endtask

    initial begin
        digits = 16'h1234;
        step();
        step();
        chk("reset", 4'b1111, 8'hFF);
        armed = 1'b1;
        rst = 1'b0;

        // Frame 1: 1234, plain.
        check_frame("f1", 4'b0000, 8'h99, 8'hB0, 8'hA4, 8'hF9);

        // Frame 2: inputs change at idx=2 but the frame keeps 1234.
        check_slot("f2_d0", 4'b1110, 8'h99);
        check_slot("f2_d1", 4'b1101, 8'hB0);
        digits = 16'h5678;
        check_slot("f2_d2", 4'b1011, 8'hA4);
        check_slot("f2_d3", 4'b0111, 8'hF9);

        // Frame 3: new digits appear.
        check_frame("f3", 4'b0000, 8'h80, 8'hF8, 8'h82, 8'h92);

        // Frame 4: digit 2 blanked, dp on digits 0 and 2 (2 stays dark).
        digits = 16'h0909;
        blank_mask = 4'b0100;
        dp_mask = 4'b0101;
        check_frame("f4", 4'b0100, 8'h10, 8'hC0, 8'hFF, 8'hC0);

        // Frames 5-9: digit 0 blinks, lit 5-6, dark 7-8, lit 9.
        digits = 16'h1234;
        blank_mask = 4'b0000;
        dp_mask = 4'b0000;
        blink_mask = 4'b0001;
        check_frame("f5", 4'b0000, 8'h99, 8'hB0, 8'hA4, 8'hF9);
        check_frame("f6", 4'b0000, 8'h99, 8'hB0, 8'hA4, 8'hF9);
        check_frame("f7", 4'b0001, 8'h99, 8'hB0, 8'hA4, 8'hF9);
        check_frame("f8", 4'b0001, 8'h99, 8'hB0, 8'hA4, 8'hF9);
        check_frame("f9", 4'b0000, 8'h99, 8'hB0, 8'hA4, 8'hF9);

        // Frame 10: non-BCD codes light the anode with segments off; dp on digit 3.
        digits = 16'hFA00;
        blink_mask = 4'b0000;
        dp_mask = 4'b1000;
        check_frame("f10", 4'b0000, 8'hC0, 8'hC0, 8'hFF, 8'h7F);

        // Frame 11 (blink phase 1): reset in the middle of slot 2.
        digits = 16'h1234;
        dp_mask = 4'b0000;
        check_slot("f11_d0", 4'b1110, 8'h99);
        check_slot("f11_d1", 4'b1101, 8'hB0);
        step();
        chk("f11_d2_gap0", 4'b1111, 8'hFF);
        step();
        chk("f11_d2_gap1", 4'b1111, 8'hFF);
        step();
        chk("f11_d2_lit", 4'b1011, 8'hA4);
        rst = 1'b1;
        blink_mask = 4'b0001;
        step();
        chk("mid_reset", 4'b1111, 8'hFF);
        rst = 1'b0;

        // After reset the blink phase is 0, so digit 0 is lit and scanning starts at 0.
        check_frame("post_rst", 4'b0000, 8'h99, 8'hB0, 8'hA4, 8'hF9);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
